// File: rtl/pe_ctrl_pkg.sv
// Shared encodings for the PE row sequencer: modes, select patterns and FSM states.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FP_S1 = 2'd0,
        MODE_FP_S2 = 2'd1,
        MODE_BP_S1 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic m0;
        logic m1;
        logic m2;
        logic m3;
        logic s0;
        logic s1;
    } sel_t;

    localparam sel_t SEL_FP_S1 = 6'b0000_10;
    localparam sel_t SEL_FP_S2 = 6'b1010_11;
    localparam sel_t SEL_BP_S1 = 6'b0101_01;

    // Reserved mode never reaches here; it leaves the selects untouched.
    function automatic sel_t sel_pattern(input mode_e m);
        case (m)
            MODE_FP_S2: return SEL_FP_S2;
            MODE_BP_S1: return SEL_BP_S1;
            default:    return SEL_FP_S1;
        endcase
    endfunction

endpackage

// File: rtl/pe_valid_delay.sv
// Valid shift register mirroring the PE pipeline: a beat emerges PE_LAT+1 cycles later.
module pe_valid_delay #(
    parameter int PE_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_vld,
    output logic out_vld,
    output logic empty
);
    localparam int STAGES = PE_LAT + 1;

    logic [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
    end

    assign out_vld = vld_pipe[STAGES];
    // Nothing queued behind the output stage: the current out_vld (if any) is the last.
    assign empty   = ~|vld_pipe[STAGES-1:1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Row sequencer for one PE: latches mode/weights, clears PSUM, streams pixel pairs, flags results.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int N      = 8,
    parameter int LEN_W  = 8,
    parameter int PE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] row_len,
    input  logic [N-1:0]     w0_in,
    input  logic [N-1:0]     w1_in,
    input  logic [N-1:0]     w2_in,
    input  logic             in_valid,
    input  logic [2*N-1:0]   in_data,
    output logic             in_ready,
    output logic [N-1:0]     pe_i0,
    output logic [N-1:0]     pe_i1,
    output logic [N-1:0]     pe_w0,
    output logic [N-1:0]     pe_w1,
    output logic [N-1:0]     pe_w2,
    output logic             select_m0,
    output logic             select_m1,
    output logic             select_m2,
    output logic             select_m3,
    output logic             select0,
    output logic             select1,
    output logic             psum_clr,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e           state, state_nxt;
    mode_e            mode_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    sel_t             sel_q;
    logic             beat;
    logic             last_beat;
    logic             dly_empty;

    assign beat      = in_valid && in_ready;
    // cnt peaks at row_len-1, so a full 2^LEN_W-1 row never wraps.
    assign last_beat = (cnt == len_q - LEN_ONE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        psum_clr  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                psum_clr = 1'b1;
                if (mode_q == MODE_RSVD || len_q == '0) state_nxt = ST_DONE;
                else                                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (beat && last_beat) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dly_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_FP_S1;
            len_q  <= '0;
            cnt    <= '0;
            pe_i0  <= '0;
            pe_i1  <= '0;
            pe_w0  <= '0;
            pe_w1  <= '0;
            pe_w2  <= '0;
            sel_q  <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start) begin
                    mode_q <= mode_e'(mode);
                    len_q  <= row_len;
                    pe_w0  <= w0_in;
                    pe_w1  <= w1_in;
                    pe_w2  <= w2_in;
                    cnt    <= '0;
                    err    <= 1'b0;
                end
                ST_LOAD: begin
                    if (mode_q == MODE_RSVD) err   <= 1'b1;
                    else                     sel_q <= sel_pattern(mode_q);
                end
                ST_RUN: if (beat) begin
                    {pe_i1, pe_i0} <= in_data;
                    cnt            <= cnt + LEN_ONE;
                end
                default: ;
            endcase
        end
    end

    assign select_m0 = sel_q.m0;
    assign select_m1 = sel_q.m1;
    assign select_m2 = sel_q.m2;
    assign select_m3 = sel_q.m3;
    assign select0   = sel_q.s0;
    assign select1   = sel_q.s1;

    pe_valid_delay #(.PE_LAT(PE_LAT)) u_vld_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (beat),
        .out_vld (out_valid),
        .empty   (dly_empty)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: directed rows with hand-derived event cycles.
module tb_pe_seq_ctrl;
    localparam int N  = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A (PE_LAT=1)
    logic          start, in_valid;
    logic [1:0]    mode;
    logic [LW-1:0] row_len;
    logic [N-1:0]  w0_in, w1_in, w2_in;
    logic [2*N-1:0] in_data;
    logic          in_ready, select_m0, select_m1, select_m2, select_m3, select0, select1;
    logic          psum_clr, out_valid, busy, done, err;
    logic [N-1:0]  pe_i0, pe_i1, pe_w0, pe_w1, pe_w2;

    // DUT B (PE_LAT=3)
    logic          start_b, in_valid_b;
    logic [1:0]    mode_b;
    logic [LW-1:0] row_len_b;
    logic [2*N-1:0] in_data_b;
    logic          in_ready_b, sm0_b, sm1_b, sm2_b, sm3_b, s0_b, s1_b;
    logic          psum_clr_b, out_valid_b, busy_b, done_b, err_b;
    logic [N-1:0]  i0_b, i1_b, w0_b, w1_b, w2_b;

    pe_seq_ctrl #(.N(N), .LEN_W(LW), .PE_LAT(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .row_len(row_len),
        .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pe_i0(pe_i0), .pe_i1(pe_i1), .pe_w0(pe_w0), .pe_w1(pe_w1),
        .pe_w2(pe_w2), .select_m0(select_m0), .select_m1(select_m1), .select_m2(select_m2),
        .select_m3(select_m3), .select0(select0), .select1(select1), .psum_clr(psum_clr),
        .out_valid(out_valid), .busy(busy), .done(done), .err(err)
    );

    pe_seq_ctrl #(.N(N), .LEN_W(LW), .PE_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b), .row_len(row_len_b),
        .w0_in(8'd1), .w1_in(8'd2), .w2_in(8'd3), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .pe_i0(i0_b), .pe_i1(i1_b), .pe_w0(w0_b), .pe_w1(w1_b),
        .pe_w2(w2_b), .select_m0(sm0_b), .select_m1(sm1_b), .select_m2(sm2_b),
        .select_m3(sm3_b), .select0(s0_b), .select1(s1_b), .psum_clr(psum_clr_b),
        .out_valid(out_valid_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int cyc; logic [7:0] i0; logic [7:0] i1; } ov_t;
    typedef struct { int cyc; logic e; logic [5:0] sel; logic [7:0] w0; logic [7:0] w1; logic [7:0] w2; } dn_t;
    ov_t ov_q[$];
    dn_t dn_q[$];
    int  ps_q[$];

    logic [7:0] p_i0 [16];
    logic [7:0] p_i1 [16];

    int gcyc = 0;
    int t0 = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    // Scoreboard monitor for DUT A
    int rel, pse;
    ov_t oe;
    dn_t de;
    logic [7:0] prev_i0 = '0, prev_i1 = '0;
    int n_busy = 0, n_rdy = 0, n_done = 0;
    always @(negedge clk) begin
        rel = gcyc - t0;
        if (reset_n) begin
            if (busy) n_busy++;
            if (in_ready) n_rdy++;
            if (out_valid) begin
                if (ov_q.size() == 0) check("ov_unexpected_cycle", rel, -1);
                else begin
                    oe = ov_q.pop_front();
                    check("ov_cycle", rel, oe.cyc);
                    check("ov_i0", prev_i0, oe.i0);
                    check("ov_i1", prev_i1, oe.i1);
                end
            end
            if (psum_clr) begin
                check("psum_with_ov", out_valid, 0);
                check("err_clr_at_load", err, 0);
                if (ps_q.size() == 0) check("psum_unexpected_cycle", rel, -1);
                else begin
                    pse = ps_q.pop_front();
                    check("psum_cycle", rel, pse);
                end
            end
            if (done) begin
                n_done++;
                if (dn_q.size() == 0) check("done_unexpected_cycle", rel, -1);
                else begin
                    de = dn_q.pop_front();
                    check("done_cycle", rel, de.cyc);
                    check("done_err", err, de.e);
                    check("done_sel", {select_m0, select_m1, select_m2, select_m3, select0, select1}, de.sel);
                    check("done_w", {pe_w0, pe_w1, pe_w2}, {de.w0, de.w1, de.w2});
                end
            end
        end
        prev_i0 = pe_i0;
        prev_i1 = pe_i1;
    end

    // Event capture for DUT B
    int t_b = 0, rel_b, ov_b = 0, first_b = -1, last_b = -1, done_rel_b = -1, n_done_b = 0;
    always @(negedge clk) begin
        rel_b = gcyc - t_b;
        if (reset_n) begin
            if (out_valid_b) begin
                ov_b++;
                if (first_b < 0) first_b = rel_b;
                last_b = rel_b;
            end
            if (done_b) begin
                n_done_b++;
                done_rel_b = rel_b;
            end
        end
    end

    task automatic push_ov(input int c, input logic [7:0] a, input logic [7:0] b);
        ov_t x;
        x.cyc = c; x.i0 = a; x.i1 = b;
        ov_q.push_back(x);
    endtask

    task automatic push_dn(input int c, input logic e, input logic [5:0] s,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        dn_t x;
        x.cyc = c; x.e = e; x.sel = s; x.w0 = a; x.w1 = b; x.w2 = d;
        dn_q.push_back(x);
    endtask

    task automatic run_row(input logic [1:0] m, input int len, input int stall_c, input int restart_c,
                           input int p_base, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                           input int exp_busy, input int exp_rdy);
        int idx, d0, b0, r0;
        bit fin;
        idx = 0; fin = 0;
        @(posedge clk); #1;
        t0 = gcyc; d0 = n_done; b0 = n_busy; r0 = n_rdy;
        row_len = len[LW-1:0]; w0_in = a; w1_in = b; w2_in = d;
        for (int c = 0; c < 40 && !fin; c++) begin
            start    = (c == 0) || (c == restart_c);
            mode     = (c == restart_c) ? 2'd2 : m;
            in_valid = (c != stall_c) && (idx < len);
            in_data  = {p_i1[p_base + idx], p_i0[p_base + idx]};
            @(negedge clk); #1;
            if (in_valid && in_ready) idx++;
            if (n_done != d0) fin = 1;
            else begin @(posedge clk); #1; end
        end
        start = 0; in_valid = 0;
        if (!fin) check("row_timeout", 0, 1);
        check("busy_cycles", n_busy - b0, exp_busy);
        check("ready_cycles", n_rdy - r0, exp_rdy);
        check("ov_missing", ov_q.size(), 0);
        check("psum_missing", ps_q.size(), 0);
        check("done_missing", dn_q.size(), 0);
    endtask

    initial begin
        start = 0; mode = 0; row_len = 0; w0_in = 0; w1_in = 0; w2_in = 0; in_valid = 0; in_data = 0;
        start_b = 0; mode_b = 0; row_len_b = 0; in_valid_b = 0; in_data_b = 0;
        for (int i = 0; i < 16; i++) begin p_i0[i] = 8'd0; p_i1[i] = 8'd0; end
        p_i0[0] = 8'd1; p_i1[0] = 8'd2;
        p_i0[1] = 8'd1; p_i1[1] = 8'd3;
        p_i0[2] = 8'd1; p_i1[2] = 8'd4;
        p_i0[3] = 8'd7; p_i1[3] = 8'd8;
        p_i0[4] = 8'd9; p_i1[4] = 8'd10;
        p_i0[5] = 8'd11; p_i1[5] = 8'd12;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, pe_i0, pe_i1, pe_w0, pe_w1, pe_w2, select_m0, select_m1,
              select_m2, select_m3, select0, select1, psum_clr, out_valid, busy, done, err}, 0);
        reset_n = 1;

        // mode0, continuous
        ps_q.push_back(1);
        push_ov(4, 8'd1, 8'd2); push_ov(5, 8'd1, 8'd3); push_ov(6, 8'd1, 8'd4);
        push_dn(7, 1'b0, 6'b000010, 8'd1, 8'd2, 8'd3);
        run_row(2'd0, 3, -1, -1, 0, 8'd1, 8'd2, 8'd3, 7, 3);

        // mode0, stall in cycle 3
        ps_q.push_back(1);
        push_ov(4, 8'd1, 8'd2); push_ov(6, 8'd1, 8'd3); push_ov(7, 8'd1, 8'd4);
        push_dn(8, 1'b0, 6'b000010, 8'd1, 8'd2, 8'd3);
        run_row(2'd0, 3, 3, -1, 0, 8'd1, 8'd2, 8'd3, 8, 4);

        // reserved mode: err, selects unchanged, no beats
        ps_q.push_back(1);
        push_dn(2, 1'b1, 6'b000010, 8'd9, 8'd9, 8'd9);
        run_row(2'd3, 3, -1, -1, 0, 8'd9, 8'd9, 8'd9, 2, 0);
        repeat (2) @(posedge clk);
        #1 check("err_sticky", err, 1);

        // mode1, row_len=0
        ps_q.push_back(1);
        push_dn(2, 1'b0, 6'b101011, 8'd1, 8'd1, 8'd1);
        run_row(2'd1, 0, -1, -1, 0, 8'd1, 8'd1, 8'd1, 2, 0);

        // start (with mode2) during RUN is ignored
        ps_q.push_back(1);
        push_ov(4, 8'd1, 8'd2); push_ov(5, 8'd1, 8'd3); push_ov(6, 8'd1, 8'd4);
        push_dn(7, 1'b0, 6'b000010, 8'd1, 8'd2, 8'd3);
        run_row(2'd0, 3, -1, 3, 0, 8'd1, 8'd2, 8'd3, 7, 3);

        // reset mid-RUN: row abandoned
        @(posedge clk); #1;
        t0 = gcyc;
        ps_q.push_back(1);
        start = 1; mode = 2'd2; row_len = 8'd3; w0_in = 8'd4; w1_in = 8'd5; w2_in = 8'd6;
        in_valid = 1; in_data = {8'd6, 8'd5};
        @(posedge clk); #1 start = 0;
        repeat (2) @(posedge clk);
        #1 check("pre_reset_i0", pe_i0, 5);
        reset_n = 0;
        #1;
        check("midrun_reset_outputs", {in_ready, pe_i0, pe_i1, pe_w0, pe_w1, pe_w2, select_m0, select_m1,
              select_m2, select_m3, select0, select1, psum_clr, out_valid, busy, done, err}, 0);
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (4) @(posedge clk);
        #1 check("no_done_after_reset", n_done, 5);
        check("psum_missing_abort", ps_q.size(), 0);

        // fresh mode2 row after reset
        ps_q.push_back(1);
        push_ov(4, 8'd7, 8'd8); push_ov(5, 8'd9, 8'd10); push_ov(6, 8'd11, 8'd12);
        push_dn(7, 1'b0, 6'b010101, 8'd4, 8'd5, 8'd6);
        run_row(2'd2, 3, -1, -1, 3, 8'd4, 8'd5, 8'd6, 7, 3);

        // PE_LAT=3, max row length
        @(posedge clk); #1;
        t_b = gcyc;
        start_b = 1; mode_b = 2'd0; row_len_b = 8'd255; in_valid_b = 1; in_data_b = 16'h0201;
        @(posedge clk); #1 start_b = 0;
        for (int c = 0; c < 400 && n_done_b == 0; c++) @(posedge clk);
        #1;
        in_valid_b = 0;
        check("b_done_seen", n_done_b, 1);
        check("b_ov_count", ov_b, 255);
        check("b_first_ov", first_b, 6);
        check("b_last_ov", last_b, 260);
        check("b_done_cycle", done_rel_b, 261);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
